// File: rtl/vpu_lane_issue_ctrl.sv
// Issue controller for one VPU lane: latches a request, drives the lane, pulses start, returns result + tag.
// Latency: rsp_valid_o rises delay+3 cycles after the accept; op-to-op period is delay+4 cycles.
// Backpressure: req_ready_o only in IDLE; RESP holds until rsp_ready_i. VPU_ISSUE_PERF_CNT_EN adds perf counters.
package vpu_pkg;
    localparam int OPERAND_WIDTH   = 32;
    localparam int SRC_OPERAND_CNT = 2;
    localparam int MAX_DELAY_LG2   = 3;

    typedef struct packed {
        logic fp_div;
        logic fp_mul;
        logic fp_sub;
        logic fp_add;
    } vpu_exec_req_t;
endpackage

module vpu_lane_issue_ctrl
    import vpu_pkg::*;
#(
    parameter int TAG_WIDTH = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         req_valid_i,
    output logic                                         req_ready_o,
    input  vpu_exec_req_t                                req_op_func_i,
    input  logic [MAX_DELAY_LG2-1:0]                     req_delay_i,
    input  logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0] req_operand_i,
    input  logic [SRC_OPERAND_CNT-1:0]                   req_operand_valid_i,
    input  logic [TAG_WIDTH-1:0]                         req_tag_i,
    output logic                                         start_o,
    output vpu_exec_req_t                                op_func_o,
    output logic [MAX_DELAY_LG2-1:0]                     delay_o,
    output logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0] operand_o,
    output logic [SRC_OPERAND_CNT-1:0]                   operand_valid_o,
    input  logic [OPERAND_WIDTH-1:0]                     dout_i,
    output logic                                         rsp_valid_o,
    input  logic                                         rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]                     rsp_data_o,
    output logic [TAG_WIDTH-1:0]                         rsp_tag_o,
    output logic                                         busy_o
`ifdef VPU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]                                  op_cnt_o,
    output logic [31:0]                                  busy_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [MAX_DELAY_LG2-1:0] CNT_ONE = 1;

    state_t                                        state_q;
    state_t                                        state_d;
    logic                                          lane_en;
    logic                                          accept;
    logic                                          done;
    logic                                          rsp_hs;
    vpu_exec_req_t                                 op_q;
    logic [MAX_DELAY_LG2-1:0]                      delay_q;
    logic [MAX_DELAY_LG2-1:0]                      cnt_q;
    logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0] operand_q;
    logic [SRC_OPERAND_CNT-1:0]                    operand_valid_q;
    logic [TAG_WIDTH-1:0]                          tag_q;
    logic [OPERAND_WIDTH-1:0]                      rsp_data_q;

    assign accept = req_valid_i && req_ready_o;
    assign done   = (state_q == S_WAIT) && (cnt_q == delay_q);
    assign rsp_hs = (state_q == S_RESP) && rsp_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done) state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is gated by rst_n so it stays low for the whole reset assertion.
    always_comb begin
        req_ready_o = 1'b0;
        start_o     = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        lane_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = rst_n;
                busy_o      = 1'b0;
            end
            S_ISSUE: begin
                start_o = 1'b1;
                lane_en = 1'b1;
            end
            S_WAIT:  lane_en = 1'b1;
            S_RESP:  rsp_valid_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q            <= vpu_exec_req_t'('0);
            delay_q         <= '0;
            cnt_q           <= '0;
            operand_q       <= '0;
            operand_valid_q <= '0;
            tag_q           <= '0;
            rsp_data_q      <= '0;
        end else begin
            if (accept) begin
                op_q            <= req_op_func_i;
                delay_q         <= req_delay_i;
                operand_q       <= req_operand_i;
                operand_valid_q <= req_operand_valid_i;
                tag_q           <= req_tag_i;
            end
            // Equality stop keeps cnt_q from wrapping even at the maximum delay.
            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
            end else if ((state_q == S_WAIT) && !done) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (done) begin
                rsp_data_q <= dout_i;
            end
        end
    end

    // Lane sees zeros whenever it is not computing so the column mux reads 0 when idle.
    assign op_func_o       = lane_en ? op_q : vpu_exec_req_t'('0);
    assign delay_o         = lane_en ? delay_q : '0;
    assign operand_o       = lane_en ? operand_q : '0;
    assign operand_valid_o = lane_en ? operand_valid_q : '0;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_tag_o       = tag_q;

`ifdef VPU_ISSUE_PERF_CNT_EN
    logic [31:0] op_cnt_q;
    logic [31:0] busy_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q   <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (rsp_hs && (op_cnt_q != 32'hFFFF_FFFF)) begin
                op_cnt_q <= op_cnt_q + 32'd1;
            end
            if (busy_o && (busy_cnt_q != 32'hFFFF_FFFF)) begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
        end
    end

    assign op_cnt_o   = op_cnt_q;
    assign busy_cnt_o = busy_cnt_q;
`else
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
`endif

endmodule

// File: doc/vpu_lane_issue_ctrl.md
# vpu_lane_issue_ctrl

Issue-side controller that drives one VPU_LANE: accepts an execution request over a valid/ready handshake, holds the lane's opcode, delay and operand inputs stable while the lane computes, and issues a single-cycle start pulse. It counts the requested delay, captures the lane result and returns it with the request tag over a valid/ready response channel. It sits between the VPU dispatch stage and the lane array. A lane column is built by instantiating one of these blocks per lane.

## Interface
Parameters:
- TAG_WIDTH, 4, width of the request/response tag passed through unchanged.

Widths OPERAND_WIDTH, SRC_OPERAND_CNT and MAX_DELAY_LG2, and the type vpu_exec_req_t, come from VPU_PKG.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; high only in IDLE.
- req_op_func_i  in  vpu_exec_req_t  operation select.
- req_delay_i  in  MAX_DELAY_LG2  lane latency in cycles for this op.
- req_operand_i  in  SRC_OPERAND_CNT x OPERAND_WIDTH  source operands.
- req_operand_valid_i  in  SRC_OPERAND_CNT  per-operand valid.
- req_tag_i  in  TAG_WIDTH  request tag.
- start_o  out  1  one-cycle start pulse to the lane.
- op_func_o  out  vpu_exec_req_t  lane opcode.
- delay_o  out  MAX_DELAY_LG2  lane delay.
- operand_o  out  SRC_OPERAND_CNT x OPERAND_WIDTH  lane operands.
- operand_valid_o  out  SRC_OPERAND_CNT  lane operand valids.
- dout_i  in  OPERAND_WIDTH  lane result.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  OPERAND_WIDTH  captured result.
- rsp_tag_o  out  TAG_WIDTH  tag of the completed request.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch op_func, delay, operands, operand valids and tag, then go to ISSUE.
- ISSUE:
  - Lasts exactly one cycle, with start_o=1.
  - Clear the delay counter to 0, then go to WAIT.
- WAIT:
  - If cnt==delay_q, capture dout_i into rsp_data and go to RESP.
  - Otherwise cnt increments by 1.
  - cnt is MAX_DELAY_LG2 bits wide. The equality stop means it never wraps; the max delay of 2^MAX_DELAY_LG2-1 is legal.
- RESP:
  - rsp_valid_o=1. rsp_data_o and rsp_tag_o stay stable until the handshake.
  - On rsp_ready_i, go to IDLE.
- Lane outputs (op_func_o, delay_o, operand_o, operand_valid_o):
  - Driven from the latched registers in ISSUE and WAIT.
  - Forced to all-zero in IDLE and RESP, so the lane mux outputs 0 when idle.
- The block does not decode op_func. A request with no op bit set, or an op the lane does not implement, completes normally with whatever dout_i is (0 for an all-zero op_func).
- req_* inputs are ignored outside the IDLE handshake cycle.
- A request is never accepted in the same cycle a response completes. IDLE is always re-entered first.

## Timing
- Reset values:
  - req_ready_o=0 while rst_n is low, and 1 in the first cycle after deassertion.
  - start_o=0, rsp_valid_o=0, busy_o=0.
  - rsp_data_o=0, rsp_tag_o=0, all lane outputs 0, cnt=0.
- Cycle numbering, with the accept handshake in cycle A:
  - ISSUE is cycle A+1, where start_o=1.
  - WAIT covers cycles A+2 .. A+2+delay.
  - Capture happens at the end of A+2+delay, and rsp_valid_o rises in A+3+delay.
- Minimum op-to-op period is delay+4 cycles, with rsp_ready_i held high.
- Response backpressure: RESP holds indefinitely. The lane sees zero inputs during the stall, which does not affect the captured data.
- Reset mid-operation (any state):
  - Immediate return to IDLE with all registers zeroed.
  - The in-flight request is discarded and no response is produced.

## Configuration
- VPU_ISSUE_PERF_CNT_EN defined:
  - Adds output op_cnt_o [31:0], which increments on each response handshake.
  - Adds output busy_cnt_o [31:0], which increments on each cycle with busy_o=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- VPU_ISSUE_PERF_CNT_EN not defined: the two ports and their counters are absent, and all other behaviour is identical.

## Test plan
- Reset, then an fp_add request with delay 0, operands 32'h3F80_0000 and 32'h4000_0000, tag 3, and the lane model returning 32'h4040_0000 -> start_o pulses in A+1; rsp_valid_o rises in A+3 with data 32'h4040_0000 and tag 3.
- fp_mul with delay 5 -> operand_o is stable from A+1 through A+7; dout_i is sampled only at the end of A+7; rsp_valid_o rises in A+8.
- Delay 2^MAX_DELAY_LG2-1 -> cnt reaches the maximum without wrap; the response arrives at A+3+delay.
- rsp_ready_i held low for 10 cycles -> rsp_valid_o and data are held; req_ready_o=0 throughout; a new request is accepted only in the IDLE cycle after the handshake.
- rst_n asserted during WAIT -> all outputs are 0 immediately and no response follows; the next request completes normally.
- With VPU_ISSUE_PERF_CNT_EN defined, three back-to-back delay-1 ops -> op_cnt_o=3 and busy_cnt_o=12.
